// File: rtl/controller_if.sv
// controller_out bus: everything the pipeline controller drives into the
// LC-3 datapath.
//   slave  - controller side (drives the bus)
//   master - datapath side (fetch/decode/execute/writeback/memaccess)
// Signals: stage enables, br_taken, operand bypass selects, mem_state
// (3 idle, 0 read, 1 indirect read, 2 write).
interface controller_if;
  logic       enable_updatePC;
  logic       enable_fetch;
  logic       enable_decode;
  logic       enable_execute;
  logic       enable_writeback;
  logic       br_taken;
  logic       bypass_alu_1;
  logic       bypass_alu_2;
  logic       bypass_mem_1;
  logic       bypass_mem_2;
  logic [1:0] mem_state;

  modport slave (
    output enable_updatePC, enable_fetch, enable_decode, enable_execute,
           enable_writeback, br_taken, bypass_alu_1, bypass_alu_2,
           bypass_mem_1, bypass_mem_2, mem_state
  );

  modport master (
    input  enable_updatePC, enable_fetch, enable_decode, enable_execute,
           enable_writeback, br_taken, bypass_alu_1, bypass_alu_2,
           bypass_mem_1, bypass_mem_2, mem_state
  );
endinterface

// File: rtl/controller.sv
// Pipeline controller for the LC-3 datapath.
// Tracks per-stage valid bits, holds fetch off for BR_STALL cycles behind a
// fetched BR/JMP, sequences multi-cycle data-memory accesses and decodes
// RAW hazards between the decode and execute instructions.
// Ports:
//   clock, reset        - rising-edge clock, async active-high reset
//   complete_instr      - instruction memory ready
//   complete_data       - data memory access done
//   IMem_dout/IR/IR_Exec- instruction in fetch / decode / execute
//   NZP, psr            - branch condition field, current N/Z/P flags
//   ctrl                - controller_out bus (slave end)
//
// mem_state | meaning
// ----------+----------------------------------------------
// 3 IDLE    | no data access, pipeline may advance
// 0 READ    | data read (LD/LDR, or second half of LDI)
// 1 IND     | indirect pointer read (LDI/STI first half)
// 2 WRITE   | data write (ST/STR, or second half of STI)
module controller #(
  parameter int BR_STALL = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        complete_instr,
  input  logic        complete_data,
  input  logic [15:0] IMem_dout,
  input  logic [15:0] IR,
  input  logic [15:0] IR_Exec,
  input  logic [2:0]  NZP,
  input  logic [2:0]  psr,
  controller_if.slave ctrl
);

  localparam int CW = (BR_STALL < 1) ? 1 : $clog2(BR_STALL + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(BR_STALL);

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_STI = 4'b1011;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_LEA = 4'b1110;

  typedef enum logic [1:0] {
    MS_READ  = 2'd0,
    MS_IND   = 2'd1,
    MS_WRITE = 2'd2,
    MS_IDLE  = 2'd3
  } mem_state_t;

  mem_state_t    ms;
  logic          v_dec, v_exe, v_wb;
  logic [CW-1:0] cnt;

  logic [3:0] op_fet, op_dec, op_exe;
  logic [2:0] dst_exe;
  logic       adv, fetch_ok;
  logic       dec_alu, exe_alu_dest, br_cond;
  logic       unused_bits;

  assign op_fet  = IMem_dout[15:12];
  assign op_dec  = IR[15:12];
  assign op_exe  = IR_Exec[15:12];
  assign dst_exe = IR_Exec[11:9];

  // reset is folded in so every enable is forced low while reset is held,
  // even though complete_instr may already be high.
  assign adv      = !reset && (ms == MS_IDLE) && complete_instr;
  assign fetch_ok = adv && (cnt == '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ms    <= MS_IDLE;
      v_dec <= 1'b0;
      v_exe <= 1'b0;
      v_wb  <= 1'b0;
      cnt   <= '0;
    end else begin
      case (ms)
        MS_IDLE: begin
          if (adv && v_dec) begin
            case (op_dec)
              OP_LD, OP_LDR: ms <= MS_READ;
              OP_LDI, OP_STI: ms <= MS_IND;
              OP_ST, OP_STR: ms <= MS_WRITE;
              default: ms <= MS_IDLE;
            endcase
          end
        end
        // The indirect instruction has moved into execute by now.
        MS_IND: if (complete_data) ms <= (op_exe == OP_STI) ? MS_WRITE : MS_READ;
        default: if (complete_data) ms <= MS_IDLE;
      endcase

      // Valid bits and the stall counter only move on advancing edges, so a
      // data access or an instruction-memory wait freezes them.
      if (adv) begin
        v_dec <= fetch_ok;
        v_exe <= v_dec;
        v_wb  <= v_exe;
        if (fetch_ok && (op_fet == OP_BR || op_fet == OP_JMP))
          cnt <= CNT_LOAD;
        else if (cnt != '0)
          cnt <= cnt - CW'(1);
      end
    end
  end

  assign dec_alu      = (op_dec == OP_ADD) || (op_dec == OP_AND) || (op_dec == OP_NOT);
  assign exe_alu_dest = v_exe && ((op_exe == OP_ADD) || (op_exe == OP_AND) ||
                                  (op_exe == OP_NOT) || (op_exe == OP_LEA));
  assign br_cond      = ((op_exe == OP_BR) && |(NZP & psr)) || (op_exe == OP_JMP);

  assign ctrl.enable_updatePC  = fetch_ok;
  assign ctrl.enable_fetch     = fetch_ok;
  assign ctrl.enable_decode    = adv && v_dec;
  assign ctrl.enable_execute   = adv && v_exe;
  assign ctrl.enable_writeback = (adv && v_wb) || (ms == MS_READ && complete_data);
  assign ctrl.br_taken         = !reset && (ms == MS_IDLE) && v_exe && br_cond;
  assign ctrl.mem_state        = ms;

  assign ctrl.bypass_alu_1 = exe_alu_dest && dec_alu && (IR[8:6] == dst_exe);
  assign ctrl.bypass_alu_2 = exe_alu_dest && ((op_dec == OP_ADD) || (op_dec == OP_AND)) &&
                             !IR[5] && (IR[2:0] == dst_exe);
  assign ctrl.bypass_mem_1 = exe_alu_dest &&
                             ((op_dec == OP_ST) || (op_dec == OP_STR) || (op_dec == OP_STI)) &&
                             (IR[11:9] == dst_exe);
  assign ctrl.bypass_mem_2 = exe_alu_dest && ((op_dec == OP_LDR) || (op_dec == OP_STR)) &&
                             (IR[8:6] == dst_exe);

  assign unused_bits = ^{IR[4:3], IR_Exec[8:0], IMem_dout[11:0]};

endmodule

// File: tb/tb_controller.sv
// Testbench for the LC-3 pipeline controller. The bench plays the datapath:
// it drives the instruction stream cycle by cycle and checks the controller_out
// bus against hand-derived expectations queued per cycle.
module tb_controller;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        complete_instr = 1'b1;
  logic        complete_data = 1'b0;
  logic [15:0] IMem_dout = 16'h1000;
  logic [15:0] IR = 16'h1000;
  logic [15:0] IR_Exec = 16'h1FFF;
  logic [2:0]  NZP = 3'b000;
  logic [2:0]  psr = 3'b010;

  controller_if bus ();

  controller #(.BR_STALL(3)) dut (
    .clock          (clock),
    .reset          (reset),
    .complete_instr (complete_instr),
    .complete_data  (complete_data),
    .IMem_dout      (IMem_dout),
    .IR             (IR),
    .IR_Exec        (IR_Exec),
    .NZP            (NZP),
    .psr            (psr),
    .ctrl           (bus)
  );

  always #5 clock = ~clock;

  int          vectors = 0;
  int          miscompares = 0;
  logic [11:0] exp_q[$];

  // {updatePC, fetch, decode, execute, writeback, br_taken, alu1, alu2, mem1, mem2, mem_state}
  function automatic logic [11:0] observed();
    return {bus.enable_updatePC, bus.enable_fetch, bus.enable_decode, bus.enable_execute,
            bus.enable_writeback, bus.br_taken, bus.bypass_alu_1, bus.bypass_alu_2,
            bus.bypass_mem_1, bus.bypass_mem_2, bus.mem_state};
  endfunction

  function automatic logic [11:0] mk(input logic f, input logic d, input logic e,
                                     input logic w, input logic b,
                                     input logic [3:0] byp, input logic [1:0] ms);
    return {f, f, d, e, w, b, byp, ms};
  endfunction

  task automatic test_reset();
    logic [11:0] got, want;
    repeat (2) @(posedge clock);
    #1 exp_q.push_back(mk(0, 0, 0, 0, 0, 4'b0000, 2'd3));
    #2 got = observed();
    want = exp_q.pop_front();
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL reset_hold: got %03h expected %03h", got, want);
    end
  endtask

  task automatic test_pipeline_fill();
    logic [11:0] got, want;
    for (int i = 0; i < 6; i++) begin
      @(posedge clock);
      #1;
      if (i == 0) reset = 1'b0;
      exp_q.push_back(mk(1, i >= 1, i >= 2, i >= 3, 0, 4'b0000, 2'd3));
      #2 got = observed();
      want = exp_q.pop_front();
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL fill[%0d]: got %03h expected %03h", i, got, want);
      end
    end
  endtask

  // Control instruction fetched at cycle 0 from a full pipeline.
  task automatic test_branch(input string name, input logic [15:0] instr,
                             input logic [2:0] nzp, input logic want_br);
    logic [11:0] got, want;
    logic [3:0]  en [8];
    en = '{4'b1111, 4'b0111, 4'b0011, 4'b0001, 4'b1000, 4'b1100, 4'b1110, 4'b1111};
    for (int i = 0; i < 8; i++) begin
      @(posedge clock);
      #1;
      NZP       = nzp;
      IMem_dout = (i == 0) ? instr : 16'h1000;
      IR        = (i == 1) ? instr : 16'h1000;
      IR_Exec   = (i == 2 || i == 3) ? instr : 16'h1FFF;
      exp_q.push_back(mk(en[i][3], en[i][2], en[i][1], en[i][0], (i == 2) && want_br,
                         4'b0000, 2'd3));
      #2 got = observed();
      want = exp_q.pop_front();
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL %s[%0d]: got %03h expected %03h", name, i, got, want);
      end
    end
  endtask

  // LDI in decode at cycle 0, then an instruction-memory stall after it.
  task automatic test_ldi_access();
    logic [11:0] got, want;
    logic [15:0] ir_t [7];
    logic [15:0] ire_t [7];
    logic        cd_t [7];
    logic        ci_t [7];
    logic [3:0]  en [7];
    logic [1:0]  ms [7];
    ir_t  = '{16'hA200, 16'h1000, 16'h1000, 16'h1000, 16'h1000, 16'h1000, 16'h1000};
    ire_t = '{16'h1FFF, 16'hA200, 16'hA200, 16'hA200, 16'h1FFF, 16'h1FFF, 16'h1FFF};
    cd_t  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    ci_t  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    en    = '{4'b1111, 4'b0000, 4'b0000, 4'b0001, 4'b1111, 4'b0000, 4'b1111};
    ms    = '{2'd3, 2'd1, 2'd1, 2'd0, 2'd3, 2'd3, 2'd3};
    for (int i = 0; i < 7; i++) begin
      @(posedge clock);
      #1;
      IR             = ir_t[i];
      IR_Exec        = ire_t[i];
      complete_data  = cd_t[i];
      complete_instr = ci_t[i];
      exp_q.push_back(mk(en[i][3], en[i][2], en[i][1], en[i][0], 0, 4'b0000, ms[i]));
      #2 got = observed();
      want = exp_q.pop_front();
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL ldi[%0d]: got %03h expected %03h", i, got, want);
      end
    end
    complete_data = 1'b0;
  endtask

  // Bypass decode, ending with a STR that starts a write; reset lands mid-write.
  task automatic test_bypass_and_reset();
    logic [11:0] got, want;
    logic [15:0] ire_t [6];
    logic [15:0] ir_t [6];
    logic [3:0]  byp [6];
    logic [3:0]  en [6];
    logic [1:0]  ms [6];
    ire_t = '{16'h1261, 16'h1261, 16'h2600, 16'hE600, 16'h16E1, 16'h16E1};
    ir_t  = '{16'h1440, 16'h1481, 16'h10C0, 16'h10C0, 16'h76C0, 16'h76C0};
    byp   = '{4'b1000, 4'b0100, 4'b0000, 4'b1000, 4'b0011, 4'b0011};
    en    = '{4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b0000};
    ms    = '{2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd2};
    for (int i = 0; i < 6; i++) begin
      @(posedge clock);
      #1;
      IR_Exec = ire_t[i];
      IR      = ir_t[i];
      exp_q.push_back(mk(en[i][3], en[i][2], en[i][1], en[i][0], 0, byp[i], ms[i]));
      #2 got = observed();
      want = exp_q.pop_front();
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL bypass[%0d]: got %03h expected %03h", i, got, want);
      end
    end
    // Still inside the write cycle: no clock edge between here and the check.
    #1 reset = 1'b1;
    exp_q.push_back(mk(0, 0, 0, 0, 0, 4'b0000, 2'd3));
    #1 got = observed();
    want = exp_q.pop_front();
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL reset_mid: got %03h expected %03h", got, want);
    end
    @(posedge clock);
    #1;
    reset   = 1'b0;
    IR      = 16'h1000;
    IR_Exec = 16'h1FFF;
    exp_q.push_back(mk(1, 0, 0, 0, 0, 4'b0000, 2'd3));
    #2 got = observed();
    want = exp_q.pop_front();
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL restart: got %03h expected %03h", got, want);
    end
  endtask

  initial begin
    test_reset();
    test_pipeline_fill();
    test_branch("br_taken", 16'h0E05, 3'b111, 1'b1);
    test_branch("br_not_taken", 16'h0805, 3'b100, 1'b0);
    test_branch("jmp", 16'hC1C0, 3'b000, 1'b1);
    test_ldi_access();
    test_bypass_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish by time %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
